timer_prog: RTL

//  Programmable tick timer; parametrised successor of the fixed 1 ms timeout counter.
//  A prescaler divides clk by DIV into a tick (1 ms at 50 MHz by default).
//  A PW-bit countdown then counts `period` ticks and pulses timeout.

---
 rtl/timer_prog.sv | 100 ++++++++++
 1 files changed

// File: rtl/timer_prog.sv
// Programmable tick timer: a clk/DIV prescaler feeds a PW-bit countdown that pulses
// timeout after `period` ticks, in one-shot or periodic mode.
module timer_prog #(
    parameter int DIV = 50000,
    parameter int PW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          start,
    input  logic          stop,
    input  logic          mode,
    input  logic [PW-1:0] period,
    output logic          tick,
    output logic          timeout,
    output logic          busy,
    output logic [PW-1:0] remaining,
    output logic          err
);

    localparam int PSW = $clog2(DIV);
    localparam logic [PSW-1:0] PS_LAST = PSW'(DIV - 1);
    localparam logic [PW-1:0]  REM_ONE = PW'(1);

    if (DIV < 2) begin : g_bad_div
        $error("timer_prog: DIV must be >= 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    logic [PSW-1:0] prescaler;
    logic [PW-1:0]  period_q;
    logic           mode_q;

    // Priority per edge: stop, then start (load or retrigger), then tick/expiry.
    // NOTE: every register here is written with <= so all updates see the pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the async reset clears every register, including the latched period/mode.
        if (!rst) begin
            state     <= IDLE;
            prescaler <= '0;
            remaining <= '0;
            period_q  <= '0;
            mode_q    <= 1'b0;
            tick      <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            tick    <= 1'b0;
            timeout <= 1'b0;
            err     <= 1'b0;

            if (stop) begin
                state     <= IDLE;
                busy      <= 1'b0;
                remaining <= '0;
                prescaler <= '0;
            end else if (start) begin
                prescaler <= '0;
                if (period == '0) begin
                    err       <= 1'b1;
                    state     <= IDLE;
                    busy      <= 1'b0;
                    remaining <= '0;
                end else begin
                    state     <= RUN;
                    busy      <= 1'b1;
                    remaining <= period;
                    period_q  <= period;
                    mode_q    <= mode;
                end
            end else if (state == RUN && enable) begin
                if (prescaler == PS_LAST) begin
                    prescaler <= '0;
                    tick      <= 1'b1;
                    if (remaining == REM_ONE) begin
                        timeout <= 1'b1;
                        if (mode_q) begin
                            remaining <= period_q;
                        end else begin
                            remaining <= '0;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end
                    end else begin
                        remaining <= remaining - REM_ONE;
                    end
                end else begin
                    prescaler <= prescaler + PSW'(1);
                end
            end
        end
    end

endmodule
